// File: rtl/mac_rx_frame_filter_fifo.sv
// Store-and-forward RX frame buffer: MAC AXI-Stream in -> parser AXI-Stream out, destination MAC filter.
// Ports: s_axis_* from the MAC (never stalled), m_axis_* to the parser (first-word-fall-through),
// cfg_* filter settings, stat_* saturating drop/good counters, fifo_level = committed unread bytes.
module mac_rx_frame_filter_fifo #(
  parameter int DEPTH         = 4096,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int CNT_WIDTH     = 32,
  parameter int FILTER_EN     = 1
) (
  input  logic                     clk_125mhz,
  input  logic                     rst,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  input  logic [47:0]              cfg_local_mac,
  input  logic                     cfg_promisc,
  input  logic                     cfg_bcast_en,
  input  logic                     cfg_mcast_en,
  output logic [CNT_WIDTH-1:0]     stat_rx_good,
  output logic [CNT_WIDTH-1:0]     stat_rx_drop_err,
  output logic [CNT_WIDTH-1:0]     stat_rx_drop_filter,
  output logic [CNT_WIDTH-1:0]     stat_rx_drop_ovf,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_FRAME_LEN + 1);

  typedef enum logic [1:0] {S_RESYNC, S_HDR, S_BODY, S_DROP} wr_state_t;
  typedef enum logic [1:0] {C_FILT, C_ERR, C_OVF} cause_t;

  logic [8:0]    mem [0:DEPTH-1];

  wr_state_t     state, state_nxt;
  cause_t        cause, cause_nxt;
  logic [PW-1:0] wr_ptr_commit, wr_ptr_cur, rd_ptr, ram_rd_ptr;
  logic [LW-1:0] byte_cnt;
  logic [39:0]   hdr_sr;

  logic          wr_en, commit, rollback, cnt_inc, cnt_clr;
  logic          inc_good, inc_err, inc_filt, inc_ovf;
  logic [47:0]   dst_mac;
  logic          filter_pass, full;

  assign s_axis_tready = 1'b1;
  assign m_axis_tuser  = 1'b0;

  // Byte 5 is still on the bus when the filter decides, so it completes the address directly.
  assign dst_mac     = {hdr_sr, s_axis_tdata};
  assign filter_pass = (FILTER_EN == 0) || cfg_promisc || (dst_mac == cfg_local_mac) ||
                       ((dst_mac == 48'hFFFF_FFFF_FFFF) && cfg_bcast_en) ||
                       (dst_mac[40] && cfg_mcast_en);
  // Full is measured against bytes the parser has consumed, not against prefetch reads.
  assign full        = ((wr_ptr_cur - rd_ptr) == PW'(DEPTH));
  assign fifo_level  = wr_ptr_commit - rd_ptr;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      state <= S_RESYNC;
      cause <= C_FILT;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    inc_good  = 1'b0;
    inc_err   = 1'b0;
    inc_filt  = 1'b0;
    inc_ovf   = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        S_RESYNC: begin
          if (s_axis_tlast) state_nxt = S_HDR;
        end
        S_HDR: begin
          if (full) begin
            if (s_axis_tlast) begin
              rollback = 1'b1;
              inc_ovf  = 1'b1;
              cnt_clr  = 1'b1;
            end else begin
              state_nxt = S_DROP;
              cause_nxt = C_OVF;
            end
          end else if (s_axis_tlast && (byte_cnt < LW'(5))) begin
            // runt: shorter than a destination address
            rollback = 1'b1;
            inc_err  = 1'b1;
            cnt_clr  = 1'b1;
          end else if (byte_cnt == LW'(5)) begin
            if (!filter_pass) begin
              if (s_axis_tlast) begin
                rollback = 1'b1;
                inc_filt = 1'b1;
                cnt_clr  = 1'b1;
              end else begin
                state_nxt = S_DROP;
                cause_nxt = C_FILT;
              end
            end else if (s_axis_tlast) begin
              cnt_clr = 1'b1;
              if (s_axis_tuser) begin
                rollback = 1'b1;
                inc_err  = 1'b1;
              end else begin
                wr_en    = 1'b1;
                commit   = 1'b1;
                inc_good = 1'b1;
              end
            end else begin
              wr_en     = 1'b1;
              cnt_inc   = 1'b1;
              state_nxt = S_BODY;
            end
          end else begin
            wr_en   = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        S_BODY: begin
          if (full) begin
            if (s_axis_tlast) begin
              rollback  = 1'b1;
              inc_ovf   = 1'b1;
              cnt_clr   = 1'b1;
              state_nxt = S_HDR;
            end else begin
              state_nxt = S_DROP;
              cause_nxt = C_OVF;
            end
          end else if (byte_cnt >= LW'(MAX_FRAME_LEN)) begin
            if (s_axis_tlast) begin
              rollback  = 1'b1;
              inc_err   = 1'b1;
              cnt_clr   = 1'b1;
              state_nxt = S_HDR;
            end else begin
              state_nxt = S_DROP;
              cause_nxt = C_ERR;
            end
          end else if (s_axis_tlast) begin
            cnt_clr   = 1'b1;
            state_nxt = S_HDR;
            if (s_axis_tuser) begin
              rollback = 1'b1;
              inc_err  = 1'b1;
            end else begin
              wr_en    = 1'b1;
              commit   = 1'b1;
              inc_good = 1'b1;
            end
          end else begin
            wr_en   = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        S_DROP: begin
          if (s_axis_tlast) begin
            rollback  = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = S_HDR;
            inc_ovf   = (cause == C_OVF);
            inc_err   = (cause == C_ERR);
            inc_filt  = (cause == C_FILT);
          end
        end
        default: state_nxt = S_RESYNC;
      endcase
    end
  end

  // ---------------- write datapath ----------------
  always_ff @(posedge clk_125mhz) begin
    if (wr_en) mem[wr_ptr_cur[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      wr_ptr_cur    <= '0;
      wr_ptr_commit <= '0;
      byte_cnt      <= '0;
      hdr_sr        <= '0;
    end else begin
      if (rollback)   wr_ptr_cur <= wr_ptr_commit;
      else if (wr_en) wr_ptr_cur <= wr_ptr_cur + PW'(1);
      if (commit) wr_ptr_commit <= wr_ptr_cur + PW'(1);
      if (cnt_clr)      byte_cnt <= '0;
      else if (cnt_inc) byte_cnt <= byte_cnt + LW'(1);
      if (wr_en && (state == S_HDR)) hdr_sr <= {hdr_sr[31:0], s_axis_tdata};
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      stat_rx_good        <= '0;
      stat_rx_drop_err    <= '0;
      stat_rx_drop_filter <= '0;
      stat_rx_drop_ovf    <= '0;
    end else begin
      if (inc_good && (stat_rx_good != '1))        stat_rx_good        <= stat_rx_good + 1'b1;
      if (inc_err  && (stat_rx_drop_err != '1))    stat_rx_drop_err    <= stat_rx_drop_err + 1'b1;
      if (inc_filt && (stat_rx_drop_filter != '1)) stat_rx_drop_filter <= stat_rx_drop_filter + 1'b1;
      if (inc_ovf  && (stat_rx_drop_ovf != '1))    stat_rx_drop_ovf    <= stat_rx_drop_ovf + 1'b1;
    end
  end

  // ---------------- read side ----------------
  // Output register + prefetch register. A RAM read is issued only when its data is
  // guaranteed a free register on arrival, counting the read already in flight.
  logic       rd_pend, out_vld, pf_vld, pop, rd_issue;
  logic [8:0] ram_q, out_q, pf_q;
  logic [1:0] occ;

  assign pop      = out_vld & m_axis_tready;
  assign occ      = {1'b0, out_vld} + {1'b0, pf_vld} + {1'b0, rd_pend};
  assign rd_issue = (ram_rd_ptr != wr_ptr_commit) &&
                    ((occ <= 2'd1) || ((occ == 2'd2) && pop));

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_q[7:0];
  assign m_axis_tlast  = out_q[8];

  always_ff @(posedge clk_125mhz) begin
    if (rd_issue) ram_q <= mem[ram_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      ram_rd_ptr <= '0;
      rd_ptr     <= '0;
      rd_pend    <= 1'b0;
      out_vld    <= 1'b0;
      out_q      <= '0;
      pf_vld     <= 1'b0;
      pf_q       <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) ram_rd_ptr <= ram_rd_ptr + PW'(1);
      if (pop)      rd_ptr     <= rd_ptr + PW'(1);
      if (pop) begin
        if (pf_vld) begin
          out_q  <= pf_q;
          pf_vld <= rd_pend;
          if (rd_pend) pf_q <= ram_q;
        end else if (rd_pend) begin
          out_q <= ram_q;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (rd_pend) begin
        if (!out_vld) begin
          out_q   <= ram_q;
          out_vld <= 1'b1;
        end else begin
          pf_q   <= ram_q;
          pf_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_frame_filter_fifo.sv
// Bench for mac_rx_frame_filter_fifo: directed frames, expected bytes queued at send time,
// a negedge monitor pops and compares every output handshake.
module tb_mac_rx_frame_filter_fifo;

  logic        clk_125mhz = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [47:0] cfg_local_mac;
  logic        cfg_promisc, cfg_bcast_en, cfg_mcast_en;
  logic [31:0] stat_rx_good, stat_rx_drop_err, stat_rx_drop_filter, stat_rx_drop_ovf;
  logic [12:0] fifo_level;

  mac_rx_frame_filter_fifo #(.DEPTH(4096), .MAX_FRAME_LEN(1522), .CNT_WIDTH(32), .FILTER_EN(1)) dut (
    .clk_125mhz(clk_125mhz), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cfg_local_mac(cfg_local_mac), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en),
    .cfg_mcast_en(cfg_mcast_en),
    .stat_rx_good(stat_rx_good), .stat_rx_drop_err(stat_rx_drop_err),
    .stat_rx_drop_filter(stat_rx_drop_filter), .stat_rx_drop_ovf(stat_rx_drop_ovf),
    .fifo_level(fifo_level)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [8:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_dat;
  logic       bp_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pop plus hold-while-stalled check.
  always @(negedge clk_125mhz) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
        chk("hold_data", {55'd0, m_axis_tlast, m_axis_tdata}, {55'd0, prev_dat});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {55'd0, m_axis_tlast, m_axis_tdata}, 64'hDEAD);
        end else begin
          chk("out_byte", {54'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata},
              {54'd0, 1'b0, exp_q.pop_front()});
          out_cnt++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_dat   = {m_axis_tlast, m_axis_tdata};
    end
  end

  function automatic logic [7:0] fbyte(input logic [47:0] dst, input int seed, input int i);
    if (i < 6) return dst[47-8*i -: 8];
    return 8'(seed + i * 7);
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_125mhz);
      #1;
    end
  endtask

  task automatic send_frame(input logic [47:0] dst, input int len, input logic err,
                            input logic expect_out, input int seed);
    for (int i = 0; i < len; i++) begin
      s_axis_tdata  = fbyte(dst, seed, i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) && err;
      if (expect_out) exp_q.push_back({s_axis_tlast, s_axis_tdata});
      @(posedge clk_125mhz);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      tick(1);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    tick(3);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    s_axis_tdata = 8'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    m_axis_tready = 1'b1;
    cfg_local_mac = LOCAL; cfg_promisc = 1'b0; cfg_bcast_en = 1'b1; cfg_mcast_en = 1'b0;
    tick(3);
    // reset state
    chk("rst_tready_in", {63'd0, s_axis_tready}, 64'd1);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tdata_tlast_tuser", {54'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 64'd0);
    chk("rst_stats", {stat_rx_good, stat_rx_drop_err | stat_rx_drop_filter | stat_rx_drop_ovf}, 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst = 1'b0;

    // resync then basic pass with latency check
    send_frame(LOCAL, 3, 1'b0, 1'b0, 0);
    send_frame(LOCAL, 64, 1'b0, 1'b1, 1);
    chk("commit_level", 64'(fifo_level), 64'd64);
    chk("lat_n1_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    tick(1);
    chk("lat_n2_tvalid_low", {63'd0, m_axis_tvalid}, 64'd0);
    tick(1);
    chk("lat_n2_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    wait_drain();
    chk("good_1", 64'(stat_rx_good), 64'd1);
    chk("resync_uncounted", 64'(stat_rx_drop_err), 64'd0);

    // filter modes
    send_frame(OTHER, 64, 1'b0, 1'b0, 2);
    send_frame(BCAST, 64, 1'b0, 1'b1, 3);
    send_frame(MCAST, 64, 1'b0, 1'b0, 4);
    wait_drain();
    chk("drop_filter_2", 64'(stat_rx_drop_filter), 64'd2);
    chk("good_2", 64'(stat_rx_good), 64'd2);

    // errors: tuser, oversize, runt; then an exactly max-length frame passes
    send_frame(LOCAL, 64, 1'b1, 1'b0, 5);
    send_frame(LOCAL, 1523, 1'b0, 1'b0, 6);
    send_frame(LOCAL, 4, 1'b0, 1'b0, 7);
    tick(2);
    chk("drop_err_3", 64'(stat_rx_drop_err), 64'd3);
    chk("err_level_0", 64'(fifo_level), 64'd0);
    chk("err_no_output", {63'd0, m_axis_tvalid}, 64'd0);
    send_frame(LOCAL, 1522, 1'b0, 1'b1, 8);
    wait_drain();
    chk("good_3_maxlen", 64'(stat_rx_good), 64'd3);

    // overflow, then a frame of exactly the remaining space
    m_axis_tready = 1'b0;
    send_frame(LOCAL, 1500, 1'b0, 1'b1, 9);
    send_frame(LOCAL, 1500, 1'b0, 1'b1, 10);
    send_frame(LOCAL, 1500, 1'b0, 1'b0, 11);
    tick(1);
    chk("ovf_level_3000", 64'(fifo_level), 64'd3000);
    chk("drop_ovf_1", 64'(stat_rx_drop_ovf), 64'd1);
    send_frame(LOCAL, 1096, 1'b0, 1'b1, 12);
    tick(1);
    chk("exact_fit_level", 64'(fifo_level), 64'd4096);
    chk("exact_fit_not_ovf", 64'(stat_rx_drop_ovf), 64'd1);
    base = out_cnt;
    m_axis_tready = 1'b1;
    wait_drain();
    chk("ovf_out_count", 64'(out_cnt - base), 64'd4096);
    chk("ovf_level_0", 64'(fifo_level), 64'd0);
    chk("good_6", 64'(stat_rx_good), 64'd6);

    // random backpressure over 20 back-to-back frames
    bp_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 20; f++) send_frame(LOCAL, 60 + 2 * f, 1'b0, 1'b1, 100 + f);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_drain();
    chk("good_26", 64'(stat_rx_good), 64'd26);

    // reset while output is pending
    m_axis_tready = 1'b0;
    send_frame(LOCAL, 64, 1'b0, 1'b1, 200);
    tick(3);
    chk("pre_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    chk("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_good", 64'(stat_rx_good), 64'd0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    send_frame(LOCAL, 64, 1'b0, 1'b0, 201);
    send_frame(LOCAL, 70, 1'b0, 1'b1, 202);
    wait_drain();
    chk("post_rst_good", 64'(stat_rx_good), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
